rst_seq_gen: RTL and testbench
==============================

# rst_seq_gen

Parametrised reset sequencer between the board's raw reset/PLL-lock signals and the core domains of the Matrak FPGA top level. Inverts and conditions the active-low board reset, waits for PLL lock, stretches reset, then releases up to `NUM_RST` synchronous active-high resets in order (e.g. bus fabric, then core, then peripherals). Also re-enters reset on PLL lock loss, a software reset request or, optionally, a watchdog timeout, and records the cause.

## Interface
- `NUM_RST`, 2: number of sequenced reset outputs, 1..8.
- `STRETCH_CYC`, 16: cycles reset is held after lock is seen, ≥1.
- `GAP_CYC`, 4: cycles between successive channel releases, ≥1.
- `WDT_CYC`, 50_000_000: watchdog timeout in cycles, ≥2 (used only with `RSTSEQ_WDT_EN`).

Ports:
- `clk_i` in 1: system clock; the single clock domain of the block.
- `rst_i` in 1: asynchronous, active-low reset (board button / POR).
- `locked_i` in 1: PLL lock, asynchronous to `clk_i`; synchronised internally.
- `sw_rst_i` in 1: synchronous software reset request, sampled each cycle.
- `wdt_kick_i` in 1: watchdog reload strobe. Present only with `RSTSEQ_WDT_EN`.
- `rst_o` out NUM_RST: active-high synchronous resets; bit 0 released first.
- `ready_o` out 1: high when every `rst_o` bit is 0.
- `cause_o` out 2: last reset cause. 0 = board/POR, 1 = PLL loss, 2 = software, 3 = watchdog.

## Operation
- Synchroniser: 2-FF chain on `locked_i` produces `lock_s`. Both FFs are cleared by `rst_i`.
- FSM states:
  - HOLD: all `rst_o` = 1.
  - STRETCH: all = 1. Counter runs 0..STRETCH_CYC-1.
  - RELEASE: channels clear one by one.
  - RUN: all = 0.
- Transitions:
  - HOLD→STRETCH when `lock_s`=1 and no trigger is present.
  - STRETCH→RELEASE when the count reaches STRETCH_CYC-1. `rst_o[0]` clears on that edge.
  - In RELEASE, `rst_o[k]` clears GAP_CYC cycles after `rst_o[k-1]`.
  - RELEASE→RUN on the edge that clears `rst_o[NUM_RST-1]`.
  - NUM_RST=1: STRETCH→RUN directly.
- Triggers are evaluated in every state: `lock_s`=0 (PLL loss), `sw_rst_i`=1, watchdog expiry.
  - Any trigger: next edge → HOLD, all `rst_o` = 1, counters cleared, `cause_o` loaded.
  - Trigger arriving mid-STRETCH or mid-RELEASE restarts the whole sequence.
  - Simultaneous triggers: cause priority PLL loss (1) > watchdog (3) > software (2).
  - In HOLD, a trigger keeps HOLD and updates `cause_o`.
  - `cause_o` is sticky until the next trigger or `rst_i`.
- Counter width: `$clog2` of the largest of STRETCH_CYC, GAP_CYC, WDT_CYC, +1. Counters never wrap; they saturate/stop at terminal count.
- `rst_i` low, asynchronously and from any state:
  - FSM → HOLD.
  - `rst_o` = all ones, `ready_o` = 0, `cause_o` = 0.
  - Synchroniser and counters cleared.

## Timing
- Reset values: `rst_o` = {NUM_RST{1'b1}}, `ready_o` = 0, `cause_o` = 2'd0.
- Edge numbering: edge 1 is the first rising edge with `rst_i`=1, with `locked_i` already high.
  - `lock_s` = 1 after edge 2.
  - STRETCH is entered at edge 3.
  - `rst_o[0]` clears at edge 3+STRETCH_CYC.
  - `rst_o[k]` clears at edge 3+STRETCH_CYC+k·GAP_CYC.
- `ready_o` rises on the same edge as the last `rst_o` clear. It falls on the same edge all `rst_o` reassert.
- Trigger → reset latency:
  - `sw_rst_i` sampled at edge n: `rst_o` all ones after edge n.
  - `locked_i` falling: `rst_o` all ones after edge 3 (2 synchroniser edges + 1).
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- `RSTSEQ_WDT_EN` defined:
  - Port `wdt_kick_i` exists.
  - Watchdog counter runs only in RUN and is cleared in all other states.
  - `wdt_kick_i`=1 reloads it to 0.
  - Expiry: counter reaches WDT_CYC-1 with no kick, i.e. WDT_CYC consecutive unkicked RUN cycles. It is a trigger with cause 3.
- Not defined:
  - No `wdt_kick_i` port, no watchdog logic.
  - `cause_o` never equals 3.
  - WDT_CYC is ignored.

## Test plan
- POR sequence: NUM_RST=3, STRETCH_CYC=4, GAP_CYC=3, `locked_i`=1, release `rst_i` → `rst_o` bits clear at edges 7, 10, 13; `ready_o`=1 at edge 13; `cause_o`=0.
- PLL loss in RUN: drop `locked_i` → `rst_o`=3'b111 after edge 3; `cause_o`=1. Restore `locked_i` → full sequence repeats with identical spacing.
- Software reset mid-RELEASE: pulse `sw_rst_i` one cycle after `rst_o[0]` clears → all bits reassert next edge, `cause_o`=2, sequence restarts from STRETCH.
- Simultaneous triggers: `sw_rst_i`=1 on the same edge `lock_s` falls → `cause_o`=1.
- Async reset mid-RUN: assert `rst_i`=0 between edges → `rst_o` all ones and `cause_o`=0 immediately, without waiting for a clock edge.
- Watchdog (`RSTSEQ_WDT_EN`, WDT_CYC=10):
  - Kick every 9 cycles → no reset.
  - Stop kicking → reset on the 10th unkicked RUN cycle, `cause_o`=3.
  - Without the macro, the same stimulus (port omitted) never resets.

Source files
------------

// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
//
// Reset sequencer between the board reset / PLL-lock inputs and the core reset
// domains. The block waits for a synchronised PLL lock and holds reset for
// STRETCH_CYC cycles. It then releases NUM_RST active-high synchronous resets
// one after another, GAP_CYC cycles apart, with bit 0 released first.
//
// The block re-enters reset when PLL lock is lost, when software requests a
// reset, or (optional) when the watchdog expires. The cause of the most recent
// reset is kept in a sticky register.
//
// Optional feature macro: RSTSEQ_WDT_EN
//   Defined   -> adds the port wdt_kick_i and a RUN-state watchdog (cause 3).
//   Undefined -> no watchdog logic, and cause_o never reports 3.
//
// Ports:
//   clk_i      in  1        system clock; the only clock domain of the block
//   rst_i      in  1        asynchronous active-low board/POR reset
//   locked_i   in  1        PLL lock, asynchronous; synchronised with 2 FFs
//   sw_rst_i   in  1        synchronous software reset request
//   wdt_kick_i in  1        watchdog reload strobe (RSTSEQ_WDT_EN only)
//   rst_o      out NUM_RST  active-high synchronous resets; bit 0 released first
//   ready_o    out 1        high when every rst_o bit is 0
//   cause_o    out 2        last cause: 0 POR, 1 PLL loss, 2 software, 3 watchdog
// -----------------------------------------------------------------------------
module rst_seq_gen #(
  parameter int NUM_RST     = 2,
  parameter int STRETCH_CYC = 16,
  parameter int GAP_CYC     = 4,
  parameter int WDT_CYC     = 50_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               locked_i,
  input  logic               sw_rst_i,
`ifdef RSTSEQ_WDT_EN
  input  logic               wdt_kick_i,
`endif
  output logic [NUM_RST-1:0] rst_o,
  output logic               ready_o,
  output logic [1:0]         cause_o
);

  // One counter width covers the stretch, gap and watchdog counts.
  localparam int MAX_SG  = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int MAX_ALL = (MAX_SG > WDT_CYC) ? MAX_SG : WDT_CYC;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_PLL = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic               lock_meta_r;
  logic               lock_sync_r;
  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [NUM_RST-1:0] rst_r;
  logic [NUM_RST-1:0] rst_nxt_s;
  logic [NUM_RST-1:0] clr_s;
  logic               ready_r;
  logic [1:0]         cause_r;
  logic [1:0]         cause_nxt_s;
  logic               lock_loss_s;
  logic               wdt_exp_s;
  logic               trig_s;

  // Two-stage synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= locked_i;
      lock_sync_r <= lock_meta_r;
    end
  end

  // HOLD is the state that waits for lock. A low lock counts as a PLL-loss
  // trigger only after the sequence has left HOLD. Because of this, the
  // power-up wait for lock keeps cause 0.
  assign lock_loss_s = !lock_sync_r && (state_r != ST_HOLD);

`ifdef RSTSEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYC - 1);
  localparam logic [1:0]       CAUSE_WDT = 2'd3;

  logic [CNT_W-1:0] wdt_cnt_r;
  logic [CNT_W-1:0] wdt_nxt_s;

  assign wdt_exp_s = (state_r == ST_RUN) && (wdt_cnt_r == WDT_LAST) && !wdt_kick_i;

  // Watchdog count of consecutive unkicked RUN cycles. The count saturates.
  always_comb begin
    wdt_nxt_s = CNT_ZERO;
    if (trig_s) begin
      wdt_nxt_s = CNT_ZERO;
    end else if (state_r == ST_RUN) begin
      if (wdt_kick_i) begin
        wdt_nxt_s = CNT_ZERO;
      end else if (wdt_cnt_r != WDT_LAST) begin
        wdt_nxt_s = wdt_cnt_r + CNT_ONE;
      end else begin
        wdt_nxt_s = wdt_cnt_r;
      end
    end else begin
      wdt_nxt_s = CNT_ZERO;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdt_cnt_r <= CNT_ZERO;
    end else begin
      wdt_cnt_r <= wdt_nxt_s;
    end
  end
`else
  assign wdt_exp_s = 1'b0;
`endif

  assign trig_s = lock_loss_s || wdt_exp_s || sw_rst_i;

  // Clear the lowest asserted channel. Channels release from bit 0 upwards, so
  // the pattern is always a run of ones at the top. The result is zero on the
  // final release.
  assign clr_s = rst_r & (rst_r << 1'b1);

  // Next-state, counter, reset-pattern and cause logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rst_nxt_s   = rst_r;
    cause_nxt_s = cause_r;
    if (trig_s) begin
      state_nxt_s = ST_HOLD;
      cnt_nxt_s   = CNT_ZERO;
      rst_nxt_s   = {NUM_RST{1'b1}};
      // PLL loss outranks watchdog, and watchdog outranks software.
      if (lock_loss_s) begin
        cause_nxt_s = CAUSE_PLL;
`ifdef RSTSEQ_WDT_EN
      end else if (wdt_exp_s) begin
        cause_nxt_s = CAUSE_WDT;
`endif
      end else begin
        cause_nxt_s = CAUSE_SW;
      end
    end else begin
      case (state_r)
        ST_HOLD: begin
          rst_nxt_s = {NUM_RST{1'b1}};
          cnt_nxt_s = CNT_ZERO;
          if (lock_sync_r) begin
            state_nxt_s = ST_STRETCH;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_STRETCH: begin
          if (cnt_r == STRETCH_LAST) begin
            rst_nxt_s   = clr_s;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = (clr_s == {NUM_RST{1'b0}}) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (cnt_r == GAP_LAST) begin
            rst_nxt_s   = clr_s;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = (clr_s == {NUM_RST{1'b0}}) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          rst_nxt_s = {NUM_RST{1'b0}};
          cnt_nxt_s = CNT_ZERO;
        end
        default: begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_ZERO;
          rst_nxt_s   = {NUM_RST{1'b1}};
        end
      endcase
    end
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_HOLD;
      cnt_r   <= CNT_ZERO;
      rst_r   <= {NUM_RST{1'b1}};
      ready_r <= 1'b0;
      cause_r <= CAUSE_POR;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rst_r   <= rst_nxt_s;
      ready_r <= (rst_nxt_s == {NUM_RST{1'b0}});
      cause_r <= cause_nxt_s;
    end
  end

  assign rst_o   = rst_r;
  assign ready_o = ready_r;
  assign cause_o = cause_r;

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_gen
//
// Directed self-checking bench for rst_seq_gen. It uses NUM_RST=3,
// STRETCH_CYC=4, GAP_CYC=3 and WDT_CYC=10. Outputs are sampled 1 ns after each
// rising edge. Edge numbers in the comments count rising edges from the event
// that starts each phase.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

  localparam int NUM_RST     = 3;
  localparam int STRETCH_CYC = 4;
  localparam int GAP_CYC     = 3;
  localparam int WDT_CYC     = 10;

  logic               clk_i;
  logic               rst_i;
  logic               locked_i;
  logic               sw_rst_i;
`ifdef RSTSEQ_WDT_EN
  logic               wdt_kick_i;
`endif
  logic [NUM_RST-1:0] rst_o;
  logic               ready_o;
  logic [1:0]         cause_o;

  int checks_cnt;
  int errors_cnt;

  rst_seq_gen #(
    .NUM_RST    (NUM_RST),
    .STRETCH_CYC(STRETCH_CYC),
    .GAP_CYC    (GAP_CYC),
    .WDT_CYC    (WDT_CYC)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .locked_i  (locked_i),
    .sw_rst_i  (sw_rst_i),
`ifdef RSTSEQ_WDT_EN
    .wdt_kick_i(wdt_kick_i),
`endif
    .rst_o     (rst_o),
    .ready_o   (ready_o),
    .cause_o   (cause_o)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Walk one release sequence. Channel k must clear at edge first+k*GAP_CYC,
  // and ready must rise with the last channel.
  task automatic run_seq(input string tag, input int first);
    logic [NUM_RST-1:0] exp_rst;
    for (int e = 1; e <= first + (NUM_RST - 1) * GAP_CYC; e++) begin
      step();
      for (int k = 0; k < NUM_RST; k++) begin
        exp_rst[k] = (e < first + k * GAP_CYC);
      end
      check({tag, "_rst"}, 32'(rst_o), 32'(exp_rst));
      check({tag, "_rdy"}, 32'(ready_o), 32'(exp_rst == 3'b000));
    end
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_i      = 1'b1;
    locked_i   = 1'b1;
    sw_rst_i   = 1'b0;
`ifdef RSTSEQ_WDT_EN
    wdt_kick_i = 1'b0;
`endif
    #2 rst_i = 1'b0;
    repeat (3) step();
    check("por_rst",   32'(rst_o),   32'h7);
    check("por_rdy",   32'(ready_o), 32'h0);
    check("por_cause", 32'(cause_o), 32'h0);

    // POR release. Channels clear at edges 7, 10 and 13.
    rst_i = 1'b1;
    run_seq("por", 7);
    check("por_cause_run", 32'(cause_o), 32'h0);
    step();
    check("run_hold", 32'(rst_o), 32'h0);

    // PLL loss in RUN. Reset appears after the third edge.
    locked_i = 1'b0;
    step();
    step();
    check("pll_lat2", 32'(rst_o), 32'h0);
    step();
    check("pll_rst",   32'(rst_o),   32'h7);
    check("pll_rdy",   32'(ready_o), 32'h0);
    check("pll_cause", 32'(cause_o), 32'h1);
    step();
    check("pll_hold", 32'(rst_o), 32'h7);
    locked_i = 1'b1;
    run_seq("pll_rec", 7);
    check("pll_cause_sticky", 32'(cause_o), 32'h1);

    // Software reset from RUN. The sequence restarts from HOLD.
    sw_rst_i = 1'b1;
    step();
    sw_rst_i = 1'b0;
    check("sw_rst",   32'(rst_o),   32'h7);
    check("sw_cause", 32'(cause_o), 32'h2);
    repeat (5) step();
    check("sw_bit0", 32'(rst_o), 32'h6);
    // Software reset one cycle after bit 0 clears, which is mid-RELEASE.
    sw_rst_i = 1'b1;
    step();
    sw_rst_i = 1'b0;
    check("swrel_rst",   32'(rst_o),   32'h7);
    check("swrel_cause", 32'(cause_o), 32'h2);
    run_seq("swrel", 5);

    // Simultaneous PLL loss and software request. PLL loss wins.
    locked_i = 1'b0;
    step();
    step();
    sw_rst_i = 1'b1;
    step();
    sw_rst_i = 1'b0;
    check("sim_rst",   32'(rst_o),   32'h7);
    check("sim_cause", 32'(cause_o), 32'h1);
    locked_i = 1'b1;
    run_seq("sim_rec", 7);

    // Asynchronous reset between edges. Outputs must change with no clock edge.
    #3 rst_i = 1'b0;
    #1;
    check("async_rst",   32'(rst_o),   32'h7);
    check("async_rdy",   32'(ready_o), 32'h0);
    check("async_cause", 32'(cause_o), 32'h0);
    step();
    rst_i = 1'b1;
    run_seq("por2", 7);

    // Watchdog stimulus. Kick every 9 RUN cycles, then stop kicking.
    for (int i = 1; i <= 36; i++) begin
`ifdef RSTSEQ_WDT_EN
      wdt_kick_i = ((i % 9) == 0);
`endif
      step();
      check("wdt_kicked", 32'(rst_o), 32'h0);
    end
`ifdef RSTSEQ_WDT_EN
    wdt_kick_i = 1'b0;
`endif
    repeat (9) step();
    check("wdt_9th", 32'(rst_o), 32'h0);
    step();
`ifdef RSTSEQ_WDT_EN
    check("wdt_rst",   32'(rst_o),   32'h7);
    check("wdt_cause", 32'(cause_o), 32'h3);
`else
    check("nowdt_rst",   32'(rst_o),   32'h0);
    check("nowdt_rdy",   32'(ready_o), 32'h1);
    check("nowdt_cause", 32'(cause_o), 32'h0);
    repeat (20) step();
    check("nowdt_long", 32'(rst_o), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
